// File: rtl/rr_token_arbiter_if.sv
// Request/grant bundle between N requesters and the round-robin token arbiter.
// master = requester side, slave = arbiter side.
interface rr_token_arbiter_if #(
    parameter int unsigned N = 4
);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_id;
    logic          busy;
    logic [N-1:0]  token;

    modport master (output req, input gnt, gnt_id, busy, token);
    modport slave  (input req, output gnt, gnt_id, busy, token);
endinterface

// File: rtl/rr_token_arbiter.sv
// Round-robin arbiter with a rotating one-hot priority token, registered one-hot grant
// and a per-holder quantum that forces hand-off only when another requester is waiting.
module rr_token_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned QUANTUM = 4
) (
    input logic              clk,
    input logic              rst_n,
    rr_token_arbiter_if.slave bus
);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = $clog2(QUANTUM + 1);
    localparam logic [N-1:0]  ONE  = N'(1);
    localparam logic [CW-1:0] QMAX = CW'(QUANTUM);

    typedef enum logic {StIdle, StGrant} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] tok_id;
    logic [IW-1:0] win_id;
    logic [IW-1:0] nxt_id;
    logic          win_found;
    logic          holder_req;
    logic          others;
    logic          take;
    logic          drop;

    always_comb begin
        tok_id = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (bus.token[i]) tok_id = IW'(i);
        end
    end

    // First set request scanning upward from the token position, wrapping N-1 -> 0.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 0; k < int'(N); k++) begin
            int j;
            j = int'(tok_id) + k;
            if (j >= int'(N)) j = j - int'(N);
            if (!win_found && bus.req[j]) begin
                win_found = 1'b1;
                win_id    = IW'(j);
            end
        end
    end

    assign nxt_id     = (win_id == IW'(N - 1)) ? '0 : win_id + 1'b1;
    assign holder_req = |(bus.req & bus.gnt);
    assign others     = |(bus.req & ~bus.gnt);

    always_comb begin
        take = 1'b0;
        drop = 1'b0;
        unique case (state)
            StIdle: take = win_found;
            StGrant: begin
                if (!holder_req) begin
                    take = win_found;
                    drop = !win_found;
                end else if (cnt == QMAX) begin
                    take = others;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            bus.gnt    <= '0;
            bus.gnt_id <= '0;
            bus.busy   <= 1'b0;
            bus.token  <= ONE;
            cnt        <= '0;
        end else if (take) begin
            state      <= StGrant;
            bus.gnt    <= ONE << win_id;
            bus.gnt_id <= win_id;
            bus.busy   <= 1'b1;
            bus.token  <= ONE << nxt_id;
            cnt        <= CW'(1);
        end else if (drop) begin
            state      <= StIdle;
            bus.gnt    <= '0;
            bus.gnt_id <= '0;
            bus.busy   <= 1'b0;
            cnt        <= '0;
        end else if (state == StGrant) begin
            // Sole requester at quantum expiry restarts its own quantum.
            cnt <= (cnt == QMAX) ? CW'(1) : cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_rr_token_arbiter.sv
// Scoreboard bench for rr_token_arbiter: a behavioural model pushes expected outputs per
// edge, a monitor pops and compares them; directed plan cases plus long random traffic.
module tb_rr_token_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned Q  = 4;
    localparam int unsigned IW = $clog2(N);

    typedef struct {
        logic [N-1:0]  gnt;
        logic [IW-1:0] id;
        logic          busy;
        logic [N-1:0]  tok;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic done = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t expq[$];

    // Model state: holder index (-1 = none), consecutive cycles held, priority pointer.
    int m_hold = -1;
    int m_cnt  = 0;
    int m_ptr  = 0;

    rr_token_arbiter_if #(.N(N)) bus ();

    rr_token_arbiter #(.N(N), .QUANTUM(Q)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int find_winner(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < int'(N); k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic grant_to(input int w);
        m_hold = w;
        m_cnt  = 1;
        m_ptr  = (w + 1) % N;
    endtask

    task automatic model_step(input logic [N-1:0] r);
        int w;
        logic [N-1:0] mine;
        w = find_winner(r, m_ptr);
        if (m_hold < 0) begin
            if (w >= 0) grant_to(w);
        end else begin
            mine = N'(1) << m_hold;
            if ((r & mine) == 0) begin
                if (w >= 0) grant_to(w);
                else begin
                    m_hold = -1;
                    m_cnt  = 0;
                end
            end else if (m_cnt == int'(Q)) begin
                if ((r & ~mine) != 0) grant_to(w);
                else m_cnt = 1;
            end else begin
                m_cnt++;
            end
        end
    endtask

    // Reference model: evaluates the rules on each sampled edge and queues the result.
    initial begin
        forever begin
            exp_t e;
            @(posedge clk);
            if (!rst_n) begin
                m_hold = -1;
                m_cnt  = 0;
                m_ptr  = 0;
            end else begin
                model_step(bus.req);
            end
            e.gnt  = (m_hold < 0) ? '0 : (N'(1) << m_hold);
            e.id   = (m_hold < 0) ? '0 : IW'(m_hold);
            e.busy = (m_hold >= 0);
            e.tok  = N'(1) << m_ptr;
            expq.push_back(e);
        end
    end

    // Monitor: the DUT presents a fresh output set after every edge.
    initial begin
        forever begin
            exp_t e;
            @(posedge clk);
            #1;
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty at %0t", $time);
            end else begin
                e = expq.pop_front();
                check("gnt", 32'(bus.gnt), 32'(e.gnt));
                check("gnt_id", 32'(bus.gnt_id), 32'(e.id));
                check("busy", 32'(bus.busy), 32'(e.busy));
                check("token", 32'(bus.token), 32'(e.tok));
            end
        end
    end

    task automatic drive(input logic [N-1:0] r, input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            bus.req = r;
        end
    endtask

    initial begin
        logic [N-1:0] pat;
        int           hold_len;

        rst_n   = 1'b0;
        bus.req = '1;
        repeat (3) begin
            @(negedge clk);
            check("rst_gnt", 32'(bus.gnt), 32'h0);
            check("rst_busy", 32'(bus.busy), 32'h0);
            check("rst_token", 32'(bus.token), 32'h1);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_gnt", 32'(bus.gnt), 32'h1);

        drive(4'b1111, 22);
        drive(4'b0001, 14);
        drive(4'b0000, 2);

        // Token ends at 1000 in idle, then 0110 must scan 3 -> 0 -> 1.
        drive(4'b0100, 1);
        drive(4'b0000, 1);
        drive(4'b0110, 1);
        @(posedge clk);
        #1;
        check("wrap_gnt", 32'(bus.gnt), 32'b0010);
        check("wrap_token", 32'(bus.token), 32'b0100);

        // Early release from holder 1 to requester 3.
        drive(4'b0010, 1);
        drive(4'b1001, 1);
        @(posedge clk);
        #1;
        check("early_gnt", 32'(bus.gnt), 32'b1000);
        check("early_token", 32'(bus.token), 32'b0001);
        drive(4'b0000, 2);

        // Asynchronous reset while requester 2 holds.
        drive(4'b0100, 1);
        @(posedge clk);
        #3;
        check("pre_arst_gnt", 32'(bus.gnt), 32'b0100);
        rst_n = 1'b0;
        #1;
        check("arst_gnt", 32'(bus.gnt), 32'h0);
        check("arst_busy", 32'(bus.busy), 32'h0);
        check("arst_token", 32'(bus.token), 32'h1);
        @(negedge clk);
        rst_n   = 1'b1;
        bus.req = 4'b1000;
        @(posedge clk);
        #1;
        check("post_arst_gnt", 32'(bus.gnt), 32'b1000);
        check("post_arst_token", 32'(bus.token), 32'b0001);

        for (int n = 0; n < 600; n++) begin
            pat      = N'($urandom_range(0, (1 << N) - 1));
            hold_len = $urandom_range(1, 10);
            if ($urandom_range(0, 3) == 0) pat = N'(1) << $urandom_range(0, N - 1);
            drive(pat, hold_len);
        end

        drive(4'b0000, 2);
        done = 1'b1;
        @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
